hps_io_cmd_sequencer: RTL

Sits between the HPS SPI word interface and the core's IO handlers (config string, status, file I/O, joystick, ...). It turns the stream of 16-bit words strobed inside one io_enable frame into command, argument and response phases. It routes each frame to exactly one of N handlers and multiplexes that handler's reply word back to the HPS gp_in path. It is the single owner of the shared SPI word channel.

---
 rtl/hps_io_pkg.sv | 23 ++
 rtl/hps_io_cmd_sequencer_if.sv | 32 +++
 rtl/hps_io_cmd_match.sv | 25 ++
 rtl/hps_io_cmd_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/hps_io_pkg.sv
// Shared types and constants for the HPS IO command sequencer.
//   seq_state_e : sequencer frame state (idle, command, argument data, drop)
//   UIO_*       : standard command codes of the IO handlers
//   WordWidth   : width of one SPI word
//   IdxWidth    : width of the argument index counter
package hps_io_pkg;

  localparam int unsigned WordWidth = 16;
  localparam int unsigned IdxWidth  = 12;

  localparam logic [7:0] UIO_STATUS = 8'h01;
  localparam logic [7:0] UIO_JOY    = 8'h02;
  localparam logic [7:0] UIO_CFG    = 8'h03;
  localparam logic [7:0] UIO_FILE   = 8'h04;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDrop
  } seq_state_e;

endpackage

// File: rtl/hps_io_cmd_sequencer_if.sv
// Bundle of the HPS word channel and the handler-side bus of the sequencer.
//   HPS side    : io_enable, io_strobe, io_din (to sequencer), io_dout (from sequencer)
//   Handler side: hnd_act, hnd_cmd, hnd_wr, hnd_wdata, hnd_idx, unk_cmd (from sequencer),
//                 hnd_rdata (to sequencer, 16 bits per handler)
// Modports: master = the sequencer, slave = the HPS link plus handlers.
interface hps_io_cmd_sequencer_if
  import hps_io_pkg::*;
#(
  parameter int unsigned N_HND = 4
);
  logic                       io_enable;
  logic                       io_strobe;
  logic [WordWidth-1:0]       io_din;
  logic [WordWidth-1:0]       io_dout;
  logic [N_HND-1:0]           hnd_act;
  logic [WordWidth-1:0]       hnd_cmd;
  logic                       hnd_wr;
  logic [WordWidth-1:0]       hnd_wdata;
  logic [IdxWidth-1:0]        hnd_idx;
  logic [WordWidth*N_HND-1:0] hnd_rdata;
  logic                       unk_cmd;

  modport master (
    input  io_enable, io_strobe, io_din, hnd_rdata,
    output io_dout, hnd_act, hnd_cmd, hnd_wr, hnd_wdata, hnd_idx, unk_cmd
  );

  modport slave (
    output io_enable, io_strobe, io_din, hnd_rdata,
    input  io_dout, hnd_act, hnd_cmd, hnd_wr, hnd_wdata, hnd_idx, unk_cmd
  );
endinterface

// File: rtl/hps_io_cmd_match.sv
// Combinational command-table lookup.
//   code_i   : low byte of the command word
//   onehot_o : one-hot handler select; the lowest matching entry wins on collisions
//   hit_o    : set when any table entry matches
module hps_io_cmd_match #(
  parameter int unsigned         N_HND     = 4,
  parameter logic [8*N_HND-1:0]  CMD_TABLE = '0
) (
  input  logic [7:0]       code_i,
  output logic [N_HND-1:0] onehot_o,
  output logic             hit_o
);

  always_comb begin
    onehot_o = '0;
    hit_o    = 1'b0;
    for (int unsigned i = 0; i < N_HND; i++) begin
      if (!hit_o && (code_i == CMD_TABLE[8*i +: 8])) begin
        onehot_o[i] = 1'b1;
        hit_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hps_io_cmd_sequencer.sv
// Splits each io_enable frame of HPS SPI words into a command word and argument words,
// routes the frame to the one handler whose table code matches, and returns that handler's
// reply word on io_dout.
//   sys_clk, reset : clock and synchronous active-high reset
//   bus (master)   : HPS word channel and handler bus, see hps_io_cmd_sequencer_if
// Optional build macro HPS_IO_TIMEOUT_EN: aborts an open frame into the drop state after
// TIMEOUT cycles without a strobe, pulsing unk_cmd.
module hps_io_cmd_sequencer
  import hps_io_pkg::*;
#(
  parameter int unsigned        N_HND     = 4,
  parameter logic [8*N_HND-1:0] CMD_TABLE = {UIO_FILE, UIO_CFG, UIO_JOY, UIO_STATUS},
  parameter int unsigned        TIMEOUT   = 1024
) (
  input logic                    sys_clk,
  input logic                    reset,
  hps_io_cmd_sequencer_if.master bus
);

  localparam logic [IdxWidth-1:0] IdxMax = '1;

  seq_state_e           state_q, state_d;
  logic                 armed_q, armed_d;
  logic [WordWidth-1:0] io_dout_q, io_dout_d;
  logic [N_HND-1:0]     hnd_act_q, hnd_act_d;
  logic [WordWidth-1:0] hnd_cmd_q, hnd_cmd_d;
  logic                 hnd_wr_q, hnd_wr_d;
  logic [WordWidth-1:0] hnd_wdata_q, hnd_wdata_d;
  logic [IdxWidth-1:0]  hnd_idx_q, hnd_idx_d;
  logic                 unk_cmd_q, unk_cmd_d;

  logic [N_HND-1:0]     match_onehot;
  logic                 match_hit;
  logic [WordWidth-1:0] reply;

`ifdef HPS_IO_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  hps_io_cmd_match #(
    .N_HND    (N_HND),
    .CMD_TABLE(CMD_TABLE)
  ) u_match (
    .code_i  (bus.io_din[7:0]),
    .onehot_o(match_onehot),
    .hit_o   (match_hit)
  );

  // hnd_act is one-hot or zero, so an OR of the gated slices is the mux.
  always_comb begin
    reply = '0;
    for (int unsigned i = 0; i < N_HND; i++) begin
      if (hnd_act_q[i]) reply = reply | bus.hnd_rdata[WordWidth*i +: WordWidth];
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ~bus.io_enable;
    io_dout_d   = io_dout_q;
    hnd_act_d   = hnd_act_q;
    hnd_cmd_d   = hnd_cmd_q;
    hnd_wr_d    = 1'b0;
    hnd_wdata_d = hnd_wdata_q;
    hnd_idx_d   = hnd_idx_q;
    unk_cmd_d   = 1'b0;
`ifdef HPS_IO_TIMEOUT_EN
    tmo_cnt_d   = '0;
`endif

    if (!bus.io_enable) begin
      // Frame end: any strobe in this cycle is discarded, io_dout keeps its last word.
      state_d   = StIdle;
      hnd_act_d = '0;
      hnd_idx_d = '0;
    end else begin
      io_dout_d = reply;
      if (hnd_wr_q && (hnd_idx_q != IdxMax)) hnd_idx_d = hnd_idx_q + 1'b1;

      case (state_q)
        // Until io_enable has been seen low since reset we may be mid-frame: drop it.
        StIdle: state_d = armed_q ? StCmd : StDrop;
        StCmd: begin
          if (bus.io_strobe) begin
            hnd_cmd_d = bus.io_din;
            if (match_hit) begin
              hnd_act_d = match_onehot;
              state_d   = StData;
            end else begin
              unk_cmd_d = 1'b1;
              state_d   = StDrop;
            end
          end
        end
        StData: begin
          if (bus.io_strobe) begin
            hnd_wr_d    = 1'b1;
            hnd_wdata_d = bus.io_din;
          end
        end
        StDrop:  state_d = StDrop;
        default: state_d = StIdle;
      endcase

`ifdef HPS_IO_TIMEOUT_EN
      if (!bus.io_strobe && ((state_q == StCmd) || (state_q == StData))) begin
        if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          state_d   = StDrop;
          hnd_act_d = '0;
          unk_cmd_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      io_dout_q   <= '0;
      hnd_act_q   <= '0;
      hnd_cmd_q   <= '0;
      hnd_wr_q    <= 1'b0;
      hnd_wdata_q <= '0;
      hnd_idx_q   <= '0;
      unk_cmd_q   <= 1'b0;
`ifdef HPS_IO_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      io_dout_q   <= io_dout_d;
      hnd_act_q   <= hnd_act_d;
      hnd_cmd_q   <= hnd_cmd_d;
      hnd_wr_q    <= hnd_wr_d;
      hnd_wdata_q <= hnd_wdata_d;
      hnd_idx_q   <= hnd_idx_d;
      unk_cmd_q   <= unk_cmd_d;
`ifdef HPS_IO_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus.io_dout   = io_dout_q;
  assign bus.hnd_act   = hnd_act_q;
  assign bus.hnd_cmd   = hnd_cmd_q;
  assign bus.hnd_wr    = hnd_wr_q;
  assign bus.hnd_wdata = hnd_wdata_q;
  assign bus.hnd_idx   = hnd_idx_q;
  assign bus.unk_cmd   = unk_cmd_q;

endmodule
